// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B4 classic arbiter with round-robin grant per CYC cycle.
// Define WB_ARBITER_TIMEOUT_EN to add a stalled-strobe timeout that answers the owner with ERR.
module wb_arbiter_2m #(
    parameter int ADRW = 32,
    parameter int DW   = 32,
    parameter int SELW = 4,
    parameter int TOW  = 4
) (
    input  logic            CLK_I,
    input  logic            RST_N_I,
    input  logic            M0_CYC_I,
    input  logic            M0_STB_I,
    input  logic            M0_WE_I,
    input  logic [ADRW-1:0] M0_ADR_I,
    input  logic [DW-1:0]   M0_DAT_I,
    input  logic [SELW-1:0] M0_SEL_I,
    output logic            M0_ACK_O,
    output logic            M0_ERR_O,
    input  logic            M1_CYC_I,
    input  logic            M1_STB_I,
    input  logic            M1_WE_I,
    input  logic [ADRW-1:0] M1_ADR_I,
    input  logic [DW-1:0]   M1_DAT_I,
    input  logic [SELW-1:0] M1_SEL_I,
    output logic            M1_ACK_O,
    output logic            M1_ERR_O,
    output logic [DW-1:0]   M_DAT_O,
    output logic            S_CYC_O,
    output logic            S_STB_O,
    output logic            S_WE_O,
    output logic [ADRW-1:0] S_ADR_O,
    output logic [DW-1:0]   S_DAT_O,
    output logic [SELW-1:0] S_SEL_O,
    input  logic [DW-1:0]   S_DAT_I,
    input  logic            S_ACK_I,
    input  logic            S_ERR_I,
    output logic [1:0]      GNT_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;   // master served most recently; loses the next tie
    logic   stb_raw;
    logic   to_fire;

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) state_nxt = last ? OWN0 : OWN1;
                else if (M0_CYC_I)        state_nxt = OWN0;
                else if (M1_CYC_I)        state_nxt = OWN1;
            end
            OWN0: begin
                if (!M0_CYC_I) begin
                    last_nxt  = 1'b0;
                    state_nxt = M1_CYC_I ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!M1_CYC_I) begin
                    last_nxt  = 1'b1;
                    state_nxt = M0_CYC_I ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stb_raw = (state == OWN0) ? M0_STB_I :
                     (state == OWN1) ? M1_STB_I : 1'b0;

`ifdef WB_ARBITER_TIMEOUT_EN
    logic [TOW-1:0] to_cnt;

    assign to_fire = stb_raw && (to_cnt == {TOW{1'b1}});

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            to_cnt <= '0;
        end else if ((state_nxt != state) || !stb_raw || S_ACK_I || S_ERR_I || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    // Slave-side mux and owner-only response routing; IDLE drives the bus to zero.
    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = stb_raw & ~to_fire;
        S_WE_O   = 1'b0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_SEL_O  = '0;
        M0_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ACK_O = 1'b0;
        M1_ERR_O = 1'b0;
        case (state)
            OWN0: begin
                S_CYC_O  = M0_CYC_I;
                S_WE_O   = M0_WE_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                S_SEL_O  = M0_SEL_I;
                M0_ACK_O = S_ACK_I;
                M0_ERR_O = S_ERR_I | to_fire;
            end
            OWN1: begin
                S_CYC_O  = M1_CYC_I;
                S_WE_O   = M1_WE_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                S_SEL_O  = M1_SEL_I;
                M1_ACK_O = S_ACK_I;
                M1_ERR_O = S_ERR_I | to_fire;
            end
            default: ;
        endcase
    end

    assign M_DAT_O = S_DAT_I;
    assign GNT_O   = {state == OWN1, state == OWN0};

endmodule
